// File: rtl/alu_reg_file.sv
// Datapath core: 16x8 register file with two combinational read ports feeding an 8-op ALU.
// Write-back of the ALU result is left to the surrounding logic through the write port.

package alu_regfile_defs;
   localparam int REGFILE_ADDR_WIDTH = 4;
   localparam int REGFILE_SIZE       = 2 ** REGFILE_ADDR_WIDTH;
   localparam int REGFILE_WIDTH      = 8;
   localparam int ALU_OUTPUT_WIDTH   = REGFILE_WIDTH;

   typedef enum logic [2:0] {
      ADD_OP   = 3'd0,
      SUB_OP   = 3'd1,
      NOTA_OP  = 3'd2,
      ORAB_OP  = 3'd3,
      ANDAB_OP = 3'd4,
      NOTAB_OP = 3'd5,
      EXOR_OP  = 3'd6,
      EXNOR_OP = 3'd7
   } aluop_t;
endpackage

module alu_core
   import alu_regfile_defs::*;
(
   input  logic [REGFILE_WIDTH-1:0]    A_In,
   input  logic [REGFILE_WIDTH-1:0]    B_In,
   input  logic                        Carry_In,
   input  aluop_t                      Opcode,
   output logic [ALU_OUTPUT_WIDTH-1:0] ALU_Out,
   output logic                        Carry_Out
);

   logic [ALU_OUTPUT_WIDTH:0] result;
   logic [ALU_OUTPUT_WIDTH:0] a_ext;
   logic [ALU_OUTPUT_WIDTH:0] b_ext;
   logic [ALU_OUTPUT_WIDTH:0] c_ext;

   assign a_ext = {1'b0, A_In};
   assign b_ext = {1'b0, B_In};
   assign c_ext = {{ALU_OUTPUT_WIDTH{1'b0}}, Carry_In};

   // Bit 8 of the 9-bit result is the carry for ADD and the borrow for SUB.
   always_comb begin
      result = '0;
      case (Opcode)
         ADD_OP:   result = a_ext + b_ext + c_ext;
         SUB_OP:   result = a_ext - b_ext - c_ext;
         NOTA_OP:  result = {1'b0, ~A_In};
         ORAB_OP:  result = {1'b0, A_In | B_In};
         ANDAB_OP: result = {1'b0, A_In & B_In};
         NOTAB_OP: result = {1'b0, ~(A_In & B_In)};
         EXOR_OP:  result = {1'b0, A_In ^ B_In};
         EXNOR_OP: result = {1'b0, ~(A_In ^ B_In)};
         default:  result = '0;
      endcase
   end

   assign ALU_Out   = result[ALU_OUTPUT_WIDTH-1:0];
   assign Carry_Out = result[ALU_OUTPUT_WIDTH];

endmodule

module alu_reg_file
   import alu_regfile_defs::*;
(
   input  logic                          Clock,
   input  logic                          Reset,
   input  logic [REGFILE_ADDR_WIDTH-1:0] Read_Addr_1,
   input  logic [REGFILE_ADDR_WIDTH-1:0] Read_Addr_2,
   input  logic [REGFILE_ADDR_WIDTH-1:0] Write_Addr,
   input  logic                          Write_enable,
   input  logic [REGFILE_WIDTH-1:0]      Write_data,
   input  logic                          Carry_In,
   input  aluop_t                        Opcode,
   output logic [ALU_OUTPUT_WIDTH-1:0]   ALU_Out,
   output logic                          Carry_Out
);

   logic [REGFILE_WIDTH-1:0] regs [REGFILE_SIZE];
   logic [REGFILE_WIDTH-1:0] Data_Out_1;
   logic [REGFILE_WIDTH-1:0] Data_Out_2;

   // Reset wins over a concurrent write; no write-through bypass on reads.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         for (int i = 0; i < REGFILE_SIZE; i++) begin
            regs[i] <= '0;
         end
      end else if (Write_enable) begin
         regs[Write_Addr] <= Write_data;
      end
   end

   assign Data_Out_1 = regs[Read_Addr_1];
   assign Data_Out_2 = regs[Read_Addr_2];

   alu_core ALU_INST (
      .A_In      (Data_Out_1),
      .B_In      (Data_Out_2),
      .Carry_In  (Carry_In),
      .Opcode    (Opcode),
      .ALU_Out   (ALU_Out),
      .Carry_Out (Carry_Out)
   );

endmodule

// File: tb/tb_alu_reg_file.sv
// Directed bench for alu_reg_file: register file reset/write/read behaviour and all ALU ops.

module tb_alu_reg_file;
   import alu_regfile_defs::*;

   logic       Clock = 1'b0;
   logic       Reset = 1'b0;
   logic [3:0] Read_Addr_1 = '0;
   logic [3:0] Read_Addr_2 = '0;
   logic [3:0] Write_Addr = '0;
   logic       Write_enable = 1'b0;
   logic [7:0] Write_data = '0;
   logic       Carry_In = 1'b0;
   aluop_t     Opcode = ADD_OP;
   logic [7:0] ALU_Out;
   logic       Carry_Out;

   int passed = 0;
   int total  = 0;

   alu_reg_file DUT (
      .Clock        (Clock),
      .Reset        (Reset),
      .Read_Addr_1  (Read_Addr_1),
      .Read_Addr_2  (Read_Addr_2),
      .Write_Addr   (Write_Addr),
      .Write_enable (Write_enable),
      .Write_data   (Write_data),
      .Carry_In     (Carry_In),
      .Opcode       (Opcode),
      .ALU_Out      (ALU_Out),
      .Carry_Out    (Carry_Out)
   );

   always #5 Clock = ~Clock;

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic do_reset();
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
   endtask

   task automatic write_reg(input logic [3:0] addr, input logic [7:0] data);
      Write_Addr   = addr;
      Write_data   = data;
      Write_enable = 1'b1;
      tick();
      Write_enable = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      Opcode = NOTA_OP; Carry_In = 1'b0; Read_Addr_1 = 4'd0; Read_Addr_2 = 4'd0;
      #1;
      total++;
      if (ALU_Out !== 8'hFF || Carry_Out !== 1'b0)
         $display("FAIL reset_nota: got %h/%b expected FF/0", ALU_Out, Carry_Out);
      else passed++;
      Opcode = ADD_OP;
      #1;
      total++;
      if (ALU_Out !== 8'h00 || Carry_Out !== 1'b0)
         $display("FAIL reset_add: got %h/%b expected 00/0", ALU_Out, Carry_Out);
      else passed++;

      for (int i = 0; i < 16; i++) write_reg(4'(i), 8'hFF);
      Read_Addr_1 = 4'd9;
      #1;
      total++;
      if (DUT.Data_Out_1 !== 8'hFF)
         $display("FAIL prefill: got %h expected FF", DUT.Data_Out_1);
      else passed++;
      do_reset();
      for (int i = 0; i < 16; i++) begin
         Read_Addr_1 = 4'(i);
         Read_Addr_2 = 4'(15 - i);
         #1;
         total++;
         if (DUT.Data_Out_1 !== 8'h00 || DUT.ALU_INST.B_In !== 8'h00)
            $display("FAIL reset_clear[%0d]: got %h/%h expected 00/00",
                     i, DUT.Data_Out_1, DUT.ALU_INST.B_In);
         else passed++;
      end
   endtask

   task automatic test_walking_ones();
      logic [7:0] expected;
      do_reset();
      for (int k = 0; k < 16; k++) write_reg(4'(k), 8'(1 << (k % 8)));
      Opcode = ORAB_OP; Carry_In = 1'b0;
      for (int k = 0; k < 16; k++) begin
         expected = 8'(1 << (k % 8));
         Read_Addr_1 = 4'(k);
         Read_Addr_2 = 4'(k);
         #1;
         total++;
         if (DUT.Data_Out_1 !== expected || ALU_Out !== expected || Carry_Out !== 1'b0)
            $display("FAIL walking[%0d]: got %h/%h/%b expected %h/%h/0",
                     k, DUT.Data_Out_1, ALU_Out, Carry_Out, expected, expected);
         else passed++;
      end
   endtask

   task automatic test_alu_ops();
      logic [7:0] exp_out0 [8];
      logic       exp_c0   [8];
      logic [7:0] exp_out1 [8];
      logic       exp_c1   [8];
      exp_out0 = '{8'hFF, 8'hAB, 8'hAA, 8'hFF, 8'h00, 8'hFF, 8'hFF, 8'h00};
      exp_c0   = '{1'b0,  1'b1,  1'b0,  1'b0,  1'b0,  1'b0,  1'b0,  1'b0};
      exp_out1 = '{8'h00, 8'hAA, 8'hAA, 8'hFF, 8'h00, 8'hFF, 8'hFF, 8'h00};
      exp_c1   = '{1'b1,  1'b1,  1'b0,  1'b0,  1'b0,  1'b0,  1'b0,  1'b0};
      do_reset();
      write_reg(4'd0, 8'h55);
      write_reg(4'd1, 8'hAA);
      Read_Addr_1 = 4'd0;
      Read_Addr_2 = 4'd1;
      #1;
      total++;
      if (DUT.ALU_INST.A_In !== 8'h55 || DUT.ALU_INST.B_In !== 8'hAA)
         $display("FAIL operands: got %h/%h expected 55/AA", DUT.ALU_INST.A_In, DUT.ALU_INST.B_In);
      else passed++;
      for (int i = 0; i < 8; i++) begin
         Opcode = aluop_t'(3'(i));
         Carry_In = 1'b0;
         #1;
         total++;
         if (ALU_Out !== exp_out0[i] || Carry_Out !== exp_c0[i])
            $display("FAIL op%0d_cin0: got %h/%b expected %h/%b",
                     i, ALU_Out, Carry_Out, exp_out0[i], exp_c0[i]);
         else passed++;
         Carry_In = 1'b1;
         #1;
         total++;
         if (ALU_Out !== exp_out1[i] || Carry_Out !== exp_c1[i])
            $display("FAIL op%0d_cin1: got %h/%b expected %h/%b",
                     i, ALU_Out, Carry_Out, exp_out1[i], exp_c1[i]);
         else passed++;
      end
      Carry_In = 1'b0;
   endtask

   task automatic test_carry_boundary();
      write_reg(4'd2, 8'hF0);
      write_reg(4'd3, 8'h12);
      write_reg(4'd4, 8'h80);
      Opcode = ADD_OP; Carry_In = 1'b0;
      Read_Addr_1 = 4'd2; Read_Addr_2 = 4'd3;
      #1;
      total++;
      if (ALU_Out !== 8'h02 || Carry_Out !== 1'b1)
         $display("FAIL add_f0_12: got %h/%b expected 02/1", ALU_Out, Carry_Out);
      else passed++;
      Read_Addr_1 = 4'd4;
      #1;
      total++;
      if (ALU_Out !== 8'h92 || Carry_Out !== 1'b0)
         $display("FAIL add_80_12: got %h/%b expected 92/0", ALU_Out, Carry_Out);
      else passed++;
      Opcode = SUB_OP; Read_Addr_1 = 4'd3; Read_Addr_2 = 4'd3; Carry_In = 1'b1;
      #1;
      total++;
      if (ALU_Out !== 8'hFF || Carry_Out !== 1'b1)
         $display("FAIL sub_borrow_in: got %h/%b expected FF/1", ALU_Out, Carry_Out);
      else passed++;
      Carry_In = 1'b0;
   endtask

   task automatic test_write_read();
      do_reset();
      Opcode = NOTA_OP;
      Read_Addr_1 = 4'd5;
      Write_Addr = 4'd5; Write_data = 8'h3C; Write_enable = 1'b1;
      #1;
      total++;
      if (DUT.Data_Out_1 !== 8'h00 || ALU_Out !== 8'hFF)
         $display("FAIL before_edge: got %h/%h expected 00/FF", DUT.Data_Out_1, ALU_Out);
      else passed++;
      tick();
      total++;
      if (DUT.Data_Out_1 !== 8'h3C || ALU_Out !== 8'hC3)
         $display("FAIL after_edge: got %h/%h expected 3C/C3", DUT.Data_Out_1, ALU_Out);
      else passed++;
      Write_enable = 1'b0; Write_data = 8'h77;
      tick();
      total++;
      if (DUT.Data_Out_1 !== 8'h3C)
         $display("FAIL we_low: got %h expected 3C", DUT.Data_Out_1);
      else passed++;
      Write_enable = 1'b1; Write_data = 8'h99; Reset = 1'b1;
      tick();
      Reset = 1'b0; Write_enable = 1'b0;
      total++;
      if (DUT.Data_Out_1 !== 8'h00)
         $display("FAIL reset_over_write: got %h expected 00", DUT.Data_Out_1);
      else passed++;
   endtask

   task automatic test_back_to_back();
      do_reset();
      write_reg(4'd6, 8'h0F);
      write_reg(4'd7, 8'h3C);
      write_reg(4'd6, 8'hC3);
      Opcode = EXOR_OP; Read_Addr_1 = 4'd6; Read_Addr_2 = 4'd7;
      #1;
      total++;
      if (ALU_Out !== 8'hFF || Carry_Out !== 1'b0)
         $display("FAIL b2b_xor: got %h/%b expected FF/0", ALU_Out, Carry_Out);
      else passed++;
      Opcode = EXNOR_OP; Read_Addr_1 = 4'd7; Read_Addr_2 = 4'd7;
      #1;
      total++;
      if (ALU_Out !== 8'hFF)
         $display("FAIL same_addr_xnor: got %h expected FF", ALU_Out);
      else passed++;
      Opcode = ANDAB_OP; Read_Addr_1 = 4'd6; Read_Addr_2 = 4'd7;
      #1;
      total++;
      if (ALU_Out !== 8'h00 || DUT.Data_Out_1 !== 8'hC3)
         $display("FAIL b2b_and: got %h/%h expected 00/C3", ALU_Out, DUT.Data_Out_1);
      else passed++;
   endtask

   initial begin
      tick();
      test_reset();
      test_walking_ones();
      test_alu_ops();
      test_carry_boundary();
      test_write_read();
      test_back_to_back();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
